// File: rtl/memory_access_pkg.sv
// Shared sizing and types for the memory-access pipeline stage.
// Consumers: memory_access (top) and data_mem (storage array).
package memory_access_pkg;

    localparam int DMEM_DEPTH  = 128;
    localparam int DMEM_AW     = 7;
    localparam int STORE_CNT_W = 16;

    typedef logic [STORE_CNT_W-1:0] cnt_t;
    localparam cnt_t STORE_CNT_MAX = '1;

    // MEM/WB pipeline register contents other than the read data
    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mem_to_reg;
        logic        reg_write;
    } mw_ctrl_t;

    function automatic logic misaligned(input logic [1:0] lo, input logic access);
        return access && (lo != 2'b00);
    endfunction

endpackage

// File: rtl/memory_access_data_mem.sv
// 128 x 32 data memory: synchronous write, registered read-before-write
// read port, whole array cleared by the asynchronous active-low reset.
module data_mem
    import memory_access_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DMEM_AW-1:0] idx,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [DMEM_DEPTH];

    // rdata samples mem before this edge's write lands, so a same-index
    // store returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            rdata <= mem[idx];
            if (we) mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: data memory access, MEM/WB pipeline registers, saturating
// committed-store counter. Define MEM_ALIGN_CHK_EN for misalignment checking.
module memory_access
    import memory_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUout,
    input  logic [31:0] XM_MD,
    input  logic [4:0]  XM_RD,
    input  logic        XM_MemtoReg,
    input  logic        XM_MemWrite,
    input  logic        XM_RegWrite,
    output logic [31:0] MW_ALUout,
    output logic [31:0] MW_MDR,
    output logic [4:0]  MW_RD,
    output logic        MW_MemtoReg,
    output logic        MW_RegWrite,
    output logic [15:0] store_cnt,
    output logic        mem_err
);

    mw_ctrl_t mw_q;
    logic     misalign;
    logic     we;

`ifdef MEM_ALIGN_CHK_EN
    logic access;
    assign access   = XM_MemWrite | XM_MemtoReg;
    assign misalign = misaligned(ALUout[1:0], access);
`else
    assign misalign = 1'b0;
`endif

    assign we = XM_MemWrite & ~misalign;

    data_mem u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .idx   (ALUout[DMEM_AW+1:2]),
        .wdata (XM_MD),
        .rdata (MW_MDR)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_q      <= '0;
            store_cnt <= '0;
        end else begin
            mw_q <= '{alu:        ALUout,
                      rd:         XM_RD,
                      mem_to_reg: XM_MemtoReg,
                      reg_write:  XM_RegWrite & ~misalign};
            if (we && store_cnt != STORE_CNT_MAX)
                store_cnt <= store_cnt + cnt_t'(1);
        end
    end

`ifdef MEM_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          mem_err <= 1'b0;
        else if (misalign) mem_err <= 1'b1;
    end
`else
    assign mem_err = 1'b0;
`endif

    assign MW_ALUout   = mw_q.alu;
    assign MW_RD       = mw_q.rd;
    assign MW_MemtoReg = mw_q.mem_to_reg;
    assign MW_RegWrite = mw_q.reg_write;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// traffic compared against an array-based reference model of the stage.
module tb_memory_access;

`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ALUout = '0;
    logic [31:0] XM_MD = '0;
    logic [4:0]  XM_RD = '0;
    logic        XM_MemtoReg = 1'b0;
    logic        XM_MemWrite = 1'b0;
    logic        XM_RegWrite = 1'b0;
    logic [31:0] MW_ALUout, MW_MDR;
    logic [4:0]  MW_RD;
    logic        MW_MemtoReg, MW_RegWrite, mem_err;
    logic [15:0] store_cnt;

    int checks = 0;
    int errors = 0;

    memory_access dut (
        .clk(clk), .rst(rst), .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
        .XM_MemtoReg(XM_MemtoReg), .XM_MemWrite(XM_MemWrite), .XM_RegWrite(XM_RegWrite),
        .MW_ALUout(MW_ALUout), .MW_MDR(MW_MDR), .MW_RD(MW_RD),
        .MW_MemtoReg(MW_MemtoReg), .MW_RegWrite(MW_RegWrite),
        .store_cnt(store_cnt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Reference model: plain word array, byte address mod 512 / 4.
    logic [31:0] m_mem [128];
    int          m_cnt;
    bit          m_err;
    logic [31:0] e_alu, e_mdr;
    logic [4:0]  e_rd;
    bit          e_m2r, e_rw;

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = '0;
        m_cnt = 0; m_err = 0;
        e_alu = '0; e_mdr = '0; e_rd = '0; e_m2r = 0; e_rw = 0;
    endtask

    task automatic model_edge();
        int  w;
        bit  bad;
        w   = (ALUout % 512) / 4;
        bad = ALUout[1:0] != 2'b00 && (XM_MemWrite || XM_MemtoReg) && ALIGN;
        e_mdr = m_mem[w];
        e_alu = ALUout; e_rd = XM_RD; e_m2r = XM_MemtoReg;
        e_rw  = XM_RegWrite && !bad;
        if (XM_MemWrite && !bad) begin
            m_mem[w] = XM_MD;
            if (m_cnt < 65535) m_cnt++;
        end
        if (bad) m_err = 1;
    endtask

    // Apply one instruction for one edge; sample #1 after the edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] md, input logic [4:0] rd,
                         input bit m2r, input bit mw, input bit rw);
        ALUout = a; XM_MD = md; XM_RD = rd;
        XM_MemtoReg = m2r; XM_MemWrite = mw; XM_RegWrite = rw;
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({MW_ALUout, MW_MDR, MW_RD, MW_MemtoReg, MW_RegWrite, store_cnt, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got alu=%h mdr=%h rd=%h cnt=%h err=%b exp all zero",
                     MW_ALUout, MW_MDR, MW_RD, store_cnt, mem_err);
        end
        rst = 1'b1;
    endtask

    task automatic test_store_load();
        drive(32'h10, 32'hDEADBEEF, 5'd3, 0, 1, 0);
        drive(32'h10, 32'h0, 5'd7, 1, 0, 1);
        checks++;
        if (MW_MDR !== 32'hDEADBEEF || MW_MDR !== e_mdr) begin
            errors++; $display("FAIL store_load_mdr got %h exp %h", MW_MDR, 32'hDEADBEEF);
        end
        checks++;
        if (store_cnt !== 16'd1) begin
            errors++; $display("FAIL store_load_cnt got %h exp %h", store_cnt, 16'd1);
        end
        checks++;
        if (MW_RD !== 5'd7 || MW_MemtoReg !== 1'b1 || MW_RegWrite !== 1'b1 || MW_ALUout !== 32'h10) begin
            errors++; $display("FAIL store_load_ctrl got rd=%h m2r=%b rw=%b alu=%h exp rd=07 m2r=1 rw=1 alu=10",
                               MW_RD, MW_MemtoReg, MW_RegWrite, MW_ALUout);
        end
    endtask

    task automatic test_wrap();
        drive(32'h210, 32'hCAFEF00D, 5'd1, 0, 1, 0);
        drive(32'h010, 32'h0, 5'd1, 1, 0, 1);
        checks++;
        if (MW_MDR !== 32'hCAFEF00D) begin
            errors++; $display("FAIL wrap_mdr got %h exp %h", MW_MDR, 32'hCAFEF00D);
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h20, 32'h1, 5'd0, 0, 1, 0);
        drive(32'h20, 32'h2, 5'd0, 0, 1, 0);
        checks++;
        if (MW_MDR !== 32'h1) begin
            errors++; $display("FAIL b2b_second_edge_mdr got %h exp %h", MW_MDR, 32'h1);
        end
        drive(32'h0, 32'h0, 5'd0, 0, 0, 0);
        drive(32'h20, 32'h0, 5'd2, 1, 0, 1);
        checks++;
        if (MW_MDR !== 32'h2) begin
            errors++; $display("FAIL b2b_later_load got %h exp %h", MW_MDR, 32'h2);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit m2r, mw;
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            a[8:2] = 7'($urandom_range(0, 15));
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            mw  = $urandom_range(0, 2) == 0;
            m2r = $urandom_range(0, 2) == 0;   // both set = illegal, still defined
            drive(a, $urandom, 5'($urandom), m2r, mw, 1'($urandom));
            checks++;
            if (MW_ALUout !== e_alu || MW_MDR !== e_mdr || MW_RD !== e_rd ||
                MW_MemtoReg !== e_m2r || MW_RegWrite !== e_rw ||
                store_cnt !== 16'(m_cnt) || mem_err !== m_err) begin
                errors++;
                $display("FAIL random[%0d] got alu=%h mdr=%h rd=%h m2r=%b rw=%b cnt=%h err=%b exp alu=%h mdr=%h rd=%h m2r=%b rw=%b cnt=%h err=%b",
                         n, MW_ALUout, MW_MDR, MW_RD, MW_MemtoReg, MW_RegWrite, store_cnt, mem_err,
                         e_alu, e_mdr, e_rd, e_m2r, e_rw, 16'(m_cnt), m_err);
            end
        end
    endtask

    task automatic test_align();
        logic [15:0] cnt0;
        drive(32'h20, 32'h11111111, 5'd0, 0, 1, 0);
        cnt0 = store_cnt;
        drive(32'h22, 32'h00000BAD, 5'd9, 0, 1, 1);
        checks++;
        if (MW_RegWrite !== (ALIGN ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL align_regwrite got %b exp %b", MW_RegWrite, !ALIGN);
        end
        checks++;
        if (mem_err !== ALIGN) begin
            errors++; $display("FAIL align_mem_err got %b exp %b", mem_err, ALIGN);
        end
        checks++;
        if (store_cnt !== (ALIGN ? cnt0 : cnt0 + 16'd1)) begin
            errors++; $display("FAIL align_cnt got %h exp %h", store_cnt, ALIGN ? cnt0 : cnt0 + 16'd1);
        end
        drive(32'h20, 32'h0, 5'd0, 1, 0, 1);
        checks++;
        if (MW_MDR !== (ALIGN ? 32'h11111111 : 32'h00000BAD)) begin
            errors++; $display("FAIL align_word8 got %h exp %h", MW_MDR,
                               ALIGN ? 32'h11111111 : 32'h00000BAD);
        end
    endtask

    task automatic test_reset_mid();
        ALUout = 32'h40; XM_MD = 32'h5A5A5A5A; XM_MemWrite = 1'b1; XM_RegWrite = 1'b1;
        #3 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({MW_ALUout, MW_MDR, MW_RD, MW_MemtoReg, MW_RegWrite, store_cnt, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got alu=%h mdr=%h rd=%h cnt=%h err=%b exp all zero",
                     MW_ALUout, MW_MDR, MW_RD, store_cnt, mem_err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        foreach (m_mem[i]) if (i < 4) begin
            drive({$urandom_range(0, 7), 9'(i * 32 + 16)} & 32'hFFFF_FFFC, 32'h0, 5'd1, 1, 0, 1);
            checks++;
            if (MW_MDR !== 32'h0 || MW_MDR !== e_mdr) begin
                errors++; $display("FAIL reset_mid_load[%0d] got %h exp %h", i, MW_MDR, 32'h0);
            end
        end
        drive(32'h40, 32'h0, 5'd1, 1, 0, 1);
        checks++;
        if (MW_MDR !== 32'h0 || store_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_mid_inflight got mdr=%h cnt=%h exp mdr=0 cnt=0", MW_MDR, store_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 65535; n++)
            drive({23'd0, 7'(n), 2'b00}, 32'(n), 5'd0, 0, 1, 0);
        checks++;
        if (store_cnt !== 16'hFFFF || 16'(m_cnt) !== 16'hFFFF) begin
            errors++; $display("FAIL sat_reach got %h exp %h", store_cnt, 16'hFFFF);
        end
        drive(32'h4, 32'h77, 5'd0, 0, 1, 0);
        checks++;
        if (store_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h exp %h", store_cnt, 16'hFFFF);
        end
        drive(32'h4, 32'h0, 5'd0, 1, 0, 1);
        checks++;
        if (MW_MDR !== 32'h77 || MW_MDR !== e_mdr) begin
            errors++; $display("FAIL sat_last_store got %h exp %h", MW_MDR, 32'h77);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_back_to_back();
        test_random();
        test_align();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous and active-low; 0 = reset asserted.
REQ-003 SHALL: ALUout  input  32  effective address from the execute stage; word index = ALUout[8:2].
REQ-004 SHALL: XM_MD  input  32  store data.
REQ-005 SHALL: XM_RD  input  5  destination register number.
REQ-006 SHALL: XM_MemtoReg  input  1  load: write-back takes memory data.
REQ-007 SHALL: XM_MemWrite  input  1  store request.
REQ-008 SHALL: XM_RegWrite  input  1  write-back enable.
REQ-009 SHALL: MW_ALUout  output  32  registered ALUout.
REQ-010 SHALL: MW_MDR  output  32  registered memory read data.
REQ-011 SHALL: MW_RD  output  5  registered XM_RD.
REQ-012 SHALL: MW_MemtoReg, MW_RegWrite  output  1 each  registered controls.
REQ-013 SHALL: store_cnt  output  16  committed-store counter.
REQ-014 SHALL: mem_err  output  1  sticky misalignment flag; tied 0 when MEM_ALIGN_CHK_EN is undefined.

Function
REQ-015 SHALL: data memory is 128 x 32-bit words, indexed by ALUout[8:2]; ALUout[31:9] ignored, so addresses wrap modulo 512 bytes.
REQ-016 SHALL: on a rising edge with XM_MemWrite=1, mem[idx] <= XM_MD; write visible to reads from the next cycle.
REQ-017 SHALL: MW_MDR <= mem[idx] every cycle, using pre-write contents (read-before-write), regardless of XM_MemtoReg.
REQ-018 SHALL: MW_ALUout, MW_RD, MW_MemtoReg, MW_RegWrite register their XM_/ALUout inputs with exactly 1 cycle latency; no stall, no bubble insertion.
REQ-019 SHALL: XM_MemWrite=1 and XM_MemtoReg=1 together (illegal) perform the write and return the old word in MW_MDR.
REQ-020 SHALL: store_cnt increments by 1 per committed write; it saturates at 16'hFFFF and does not wrap.
REQ-021 SHALL: a store suppressed per REQ-027 does not increment store_cnt.

Reset
REQ-022 SHALL: while rst=0, all MW_* outputs, store_cnt and mem_err are 0, asynchronously.
REQ-023 SHALL: all 128 memory words clear to 0 on reset.
REQ-024 SHALL: a store in flight when rst asserts is lost; the first write after rst deasserts is the first edge with rst=1.

Configuration
REQ-025 SHALL: the macro MEM_ALIGN_CHK_EN enables alignment checking.
REQ-026 SHALL: with MEM_ALIGN_CHK_EN undefined, ALUout[1:0] is ignored and mem_err is constant 0.
REQ-027 SHALL: with MEM_ALIGN_CHK_EN defined, an access (XM_MemWrite or XM_MemtoReg = 1) with ALUout[1:0] != 0 suppresses the write, forces MW_RegWrite <= 0 for that instruction, and sets mem_err, which stays 1 until reset.

Structure
REQ-028 SHALL: a shared package holds DMEM_DEPTH=128, DMEM_AW=7 and the store-counter width 16.
REQ-029 SHALL: the array, write port, registered read port and its reset are one sub-module, data_mem; pipeline registers, counter and alignment check sit in memory_access.

Verification
REQ-030 SHALL: store ALUout=0x10, XM_MD=0xDEADBEEF, then load 0x10 -> MW_MDR=0xDEADBEEF one cycle after the load edge; store_cnt=1.
REQ-031 SHALL: store to 0x210, then load 0x010 -> MW_MDR equals the stored word (wrap).
REQ-032 SHALL: store 0x1 then store 0x2 to 0x20 on consecutive cycles; the second edge MW_MDR=0x1; a later load returns 0x2.
REQ-033 SHALL: preload store_cnt to 0xFFFF via 65535 stores, then one more store -> store_cnt stays 0xFFFF.
REQ-034 SHALL: with MEM_ALIGN_CHK_EN, store to 0x22 -> mem_err=1, memory word 8 unchanged, store_cnt unchanged; without the macro, word 8 is written.
REQ-035 SHALL: drive rst=0 mid-sequence between edges -> all outputs 0 immediately; a load of any address afterwards returns 0.
